// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM front-end blocks: default host address
// width (must match sdram_controller), default transaction timeout, the
// arbiter state encoding and a small grant helper.
// ---------------------------------------------------------------------------
package sdram_pkg;

  localparam int HADDR_WIDTH_DEF    = 25;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_WAIT_WR = 2'd3
  } arb_state_t;

  // One-hot two-port grant to port index (bit 1 set means port 1).
  function automatic logic grant_port(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin pick. Purely combinational; the caller owns the
// last_grant register and updates it when a grant is actually taken.
// Ports:
//   req        in  2  request vector, bit N = port N
//   last_grant in  1  index of the port granted most recently
//   grant      out 2  one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      // Contention: the port that did not win last time goes first.
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
// Round-robin front end that shares one sdram_controller between port 0
// (host bridge) and port 1 (streaming engine). One request is latched at a
// time, presented on the controller's rd/wr strobe interface, and retired as
// read data (pN_rvalid/pN_rdata) or a write-done pulse (pN_wdone). A stuck
// transaction is aborted after TIMEOUT_CYCLES and flagged in sticky err.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   pN_req/we/addr/wdata     port N request (held until pN_gnt)
//   pN_gnt                   1-cycle pulse: request latched
//   pN_rvalid/pN_rdata       read completion pulse and held read byte
//   pN_wdone                 1-cycle pulse: write retired
//   err                      sticky timeout flag
//   sd_*                     controller strobe/address/data/handshake
//
// State table:
//   state      | meaning
//   ST_IDLE    | no transaction; arbitrate and latch a request
//   ST_ISSUE   | strobe up, waiting for controller ack (may be refreshing)
//   ST_WAIT_RD | read accepted, waiting for sd_rd_ready
//   ST_WAIT_WR | write accepted, waiting for busy to rise then fall
// ---------------------------------------------------------------------------
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int HADDR_WIDTH    = HADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic [HADDR_WIDTH-1:0] p0_addr,
  input  logic [7:0]             p0_wdata,
  output logic                   p0_gnt,
  output logic                   p0_rvalid,
  output logic [7:0]             p0_rdata,
  output logic                   p0_wdone,

  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic [HADDR_WIDTH-1:0] p1_addr,
  input  logic [7:0]             p1_wdata,
  output logic                   p1_gnt,
  output logic                   p1_rvalid,
  output logic [7:0]             p1_rdata,
  output logic                   p1_wdone,

  output logic                   err,

  output logic [HADDR_WIDTH-1:0] sd_wr_addr,
  output logic [7:0]             sd_wr_data,
  output logic                   sd_wr_enable,
  output logic [HADDR_WIDTH-1:0] sd_rd_addr,
  output logic                   sd_rd_enable,
  input  logic [7:0]             sd_rd_data,
  input  logic                   sd_rd_ready,
  input  logic                   sd_ack,
  input  logic                   sd_busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t             state_q, state_d;

  logic                   cur_port;
  logic                   cur_we;
  logic [HADDR_WIDTH-1:0] cur_addr;
  logic [7:0]             cur_wdata;
  logic                   last_grant;
  logic                   seen_busy;
  logic [TMR_W-1:0]       tmr;

  logic [1:0]             req_vec;
  logic [1:0]             grant;
  logic                   win;
  logic                   tmr_tc;

  logic                   latch;
  logic                   complete_rd;
  logic                   complete_wr;
  logic                   abort;

  assign req_vec = {p1_req, p0_req};

  rr_arbiter2 u_rr (
    .req        (req_vec),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign win = grant_port(grant);

  // The timer is loaded with the full budget when a request is latched and
  // counts down once per cycle spent outside IDLE. Seeing 1 means this is
  // the last cycle of the budget, so the abort lands after exactly
  // TIMEOUT_CYCLES cycles in ISSUE/WAIT.
  assign tmr_tc = (tmr == TMR_W'(1));

  // Controller latches address/data only while a strobe is high, so these
  // can follow the latched request unconditionally.
  assign sd_wr_addr   = cur_addr;
  assign sd_rd_addr   = cur_addr;
  assign sd_wr_data   = cur_wdata;
  assign sd_rd_enable = (state_q == ST_ISSUE) && !cur_we;
  assign sd_wr_enable = (state_q == ST_ISSUE) &&  cur_we;

  always_comb begin
    state_d     = state_q;
    latch       = 1'b0;
    complete_rd = 1'b0;
    complete_wr = 1'b0;
    abort       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          latch   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sd_ack) begin
          state_d = cur_we ? ST_WAIT_WR : ST_WAIT_RD;
        end else if (tmr_tc) begin
          abort = 1'b1;
        end
      end
      ST_WAIT_RD: begin
        if (sd_rd_ready) begin
          complete_rd = 1'b1;
          state_d     = ST_IDLE;
        end else if (tmr_tc) begin
          abort = 1'b1;
        end
      end
      ST_WAIT_WR: begin
        // busy lags the ack by a cycle; only its falling edge after it
        // has been seen high means the write has retired.
        if (seen_busy && !sd_busy) begin
          complete_wr = 1'b1;
          state_d     = ST_IDLE;
        end else if (tmr_tc) begin
          abort = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_port   <= 1'b0;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      last_grant <= 1'b1;
      seen_busy  <= 1'b0;
      tmr        <= '0;
      p0_gnt     <= 1'b0;
      p1_gnt     <= 1'b0;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      p0_wdone   <= 1'b0;
      p1_wdone   <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      err        <= 1'b0;
    end else begin
      state_q   <= state_d;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_wdone  <= 1'b0;
      p1_wdone  <= 1'b0;

      if (latch) begin
        cur_port   <= win;
        cur_we     <= win ? p1_we    : p0_we;
        cur_addr   <= win ? p1_addr  : p0_addr;
        cur_wdata  <= win ? p1_wdata : p0_wdata;
        last_grant <= win;
        p0_gnt     <= !win;
        p1_gnt     <= win;
        seen_busy  <= 1'b0;
        tmr        <= TMR_W'(TIMEOUT_CYCLES);
      end else if (state_q != ST_IDLE) begin
        tmr <= tmr - TMR_W'(1);
      end

      if (state_q == ST_WAIT_WR && sd_busy) begin
        seen_busy <= 1'b1;
      end

      if (complete_rd) begin
        if (cur_port) begin
          p1_rdata  <= sd_rd_data;
          p1_rvalid <= 1'b1;
        end else begin
          p0_rdata  <= sd_rd_data;
          p0_rvalid <= 1'b1;
        end
      end

      if (complete_wr) begin
        p0_wdone <= !cur_port;
        p1_wdone <= cur_port;
      end

      if (abort) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  localparam int HW         = 25;
  localparam int RD_LEN     = 3;
  localparam int WR_LEN     = 3;
  localparam int REF_LEN    = 10;
  localparam int REF_THRESH = 1000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [HW-1:0] p0_addr, p1_addr;
  logic [7:0]    p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p0_wdone, p1_gnt, p1_rvalid, p1_wdone;
  logic [7:0]    p0_rdata, p1_rdata;
  logic          err;
  logic [HW-1:0] sd_wr_addr, sd_rd_addr;
  logic [7:0]    sd_wr_data;
  logic          sd_wr_enable, sd_rd_enable;
  logic [7:0]    sd_rd_data;
  logic          sd_rd_ready, sd_ack, sd_busy;

  always #5 clk = ~clk;

  sdram_arbiter #(.HADDR_WIDTH(HW), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_wdone(p0_wdone),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_wdone(p1_wdone),
    .err(err),
    .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data), .sd_wr_enable(sd_wr_enable),
    .sd_rd_addr(sd_rd_addr), .sd_rd_enable(sd_rd_enable), .sd_rd_data(sd_rd_data),
    .sd_rd_ready(sd_rd_ready), .sd_ack(sd_ack), .sd_busy(sd_busy)
  );

  // ---------------- behavioural controller + SDRAM ----------------
  typedef enum {M_IDLE, M_RD, M_WR, M_REF} mst_t;
  mst_t       m_st;
  int         m_cnt;
  int         ref_cnt;
  logic [9:0] m_addr;
  logic [7:0] mem [0:1023];
  logic       no_ack = 1'b0;
  logic       force_refresh = 1'b0;

  always @(posedge clk) begin
    sd_ack      <= 1'b0;
    sd_rd_ready <= 1'b0;
    if (rst) begin
      m_st       <= M_IDLE;
      m_cnt      <= 0;
      ref_cnt    <= 0;
      sd_busy    <= 1'b0;
      sd_rd_data <= 8'h00;
      m_addr     <= '0;
    end else begin
      sd_busy <= (m_st == M_RD) || (m_st == M_WR);
      ref_cnt <= force_refresh ? REF_THRESH : ref_cnt + 1;
      case (m_st)
        M_IDLE: begin
          if (ref_cnt >= REF_THRESH) begin
            m_st <= M_REF; m_cnt <= REF_LEN; ref_cnt <= 0;
          end else if (!no_ack && sd_rd_enable) begin
            sd_ack <= 1'b1; m_addr <= sd_rd_addr[9:0]; m_st <= M_RD; m_cnt <= RD_LEN;
          end else if (!no_ack && sd_wr_enable) begin
            sd_ack <= 1'b1; mem[sd_wr_addr[9:0]] <= sd_wr_data; m_st <= M_WR; m_cnt <= WR_LEN;
          end
        end
        M_RD: begin
          if (m_cnt == 0) begin
            sd_rd_ready <= 1'b1; sd_rd_data <= mem[m_addr]; m_st <= M_IDLE;
          end else m_cnt <= m_cnt - 1;
        end
        default: begin
          if (m_cnt == 0) m_st <= M_IDLE;
          else m_cnt <= m_cnt - 1;
        end
      endcase
    end
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    int         port;
    logic       we;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_gnt0 = 0, t_gnt1 = 0, t_rv0 = 0, t_err = 0;
  int   wr_strobe_cycles = 0;
  logic err_q = 1'b0;

  function automatic void push_exp(input int port, input logic we, input logic [7:0] data);
    exp_t e;
    e.port = port; e.we = we; e.data = data;
    sb.push_back(e);
  endfunction

  task automatic check_done(input int port, input logic we, input logic [7:0] data);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_completion: port=%0d we=%0b data=%02h, required none", port, we, data);
    end else begin
      e = sb.pop_front();
      if (e.port != port || e.we != we || (!we && e.data != data)) begin
        errors++;
        $display("FAIL completion: got port=%0d we=%0b data=%02h, required port=%0d we=%0b data=%02h",
                 port, we, data, e.port, e.we, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (p0_gnt || p1_gnt) begin
        checks++;
        if (p0_gnt && p1_gnt) begin
          errors++;
          $display("FAIL gnt_onehot: p0_gnt=%0b p1_gnt=%0b, required at most one", p0_gnt, p1_gnt);
        end
        if (p0_gnt) begin gnt_log.push_back(0); t_gnt0 = cyc; end
        if (p1_gnt) begin gnt_log.push_back(1); t_gnt1 = cyc; end
      end
      if (sd_rd_enable || sd_wr_enable) begin
        checks++;
        if (sd_rd_enable && sd_wr_enable) begin
          errors++;
          $display("FAIL strobe_excl: rd=%0b wr=%0b, required not both", sd_rd_enable, sd_wr_enable);
        end
      end
      if (sd_wr_enable) wr_strobe_cycles++;
      if (p0_rvalid) begin t_rv0 = cyc; check_done(0, 1'b0, p0_rdata); end
      if (p1_rvalid) check_done(1, 1'b0, p1_rdata);
      if (p0_wdone)  check_done(0, 1'b1, 8'h00);
      if (p1_wdone)  check_done(1, 1'b1, 8'h00);
      if (err && !err_q) t_err = cyc;
    end
    err_q = err;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int p, input logic r, input logic we, input logic [HW-1:0] a,
                       input logic [7:0] d);
    if (p == 0) begin p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d; end
    else        begin p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d; end
  endtask

  task automatic do_txn(input int p, input logic we, input logic [HW-1:0] a,
                        input logic [7:0] d, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    drive(p, 1'b1, we, a, d);
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      got = (p == 0) ? p0_gnt : p1_gnt;
    end
    drive(p, 1'b0, we, a, d);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL gnt_wait_p%0d: no grant within %0d cycles, required grant", p, lat);
    end else begin
      @(negedge clk);
      if (((p == 0) ? p0_gnt : p1_gnt) !== 1'b0) begin
        errors++;
        $display("FAIL gnt_pulse_p%0d: gnt=1 second cycle, required 0", p);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d completions outstanding after %0d cycles, required 0", sb.size(), n);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [82:0] v;
    v = {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_wdone, p1_wdone, err, sd_wr_enable,
         sd_rd_enable, p0_rdata, p1_rdata, sd_wr_data, sd_wr_addr, sd_rd_addr};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h, required all zero", name, v);
    end
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int          port;
    logic        we;
    logic [HW-1:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[10];
  int   alt_exp[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, la, lb, n;

    vecs[0] = '{0, 1'b1, 25'h000123, 8'hA5, 8'h00};
    vecs[1] = '{0, 1'b0, 25'h000123, 8'h00, 8'hA5};
    vecs[2] = '{1, 1'b1, 25'h000200, 8'h5A, 8'h00};
    vecs[3] = '{1, 1'b0, 25'h000200, 8'h00, 8'h5A};
    vecs[4] = '{0, 1'b0, 25'h000200, 8'h00, 8'h5A};
    vecs[5] = '{1, 1'b1, 25'h0003FF, 8'hFF, 8'h00};
    vecs[6] = '{1, 1'b0, 25'h0003FF, 8'h00, 8'hFF};
    vecs[7] = '{0, 1'b1, 25'h000123, 8'h77, 8'h00};
    vecs[8] = '{0, 1'b0, 25'h000123, 8'h00, 8'h77};
    vecs[9] = '{1, 1'b0, 25'h0003FF, 8'h00, 8'hFF};

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Single-port transactions from the table.
    for (int i = 0; i < 10; i++) begin
      push_exp(vecs[i].port, vecs[i].we, vecs[i].exp_rdata);
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      check_val($sformatf("gnt_latency_v%0d", i), lat, 1);
      drain(200);
    end

    // Simultaneous reads: p0 first, p1 the cycle after p0_rvalid.
    gnt_log.delete();
    push_exp(0, 1'b0, 8'h77);
    push_exp(1, 1'b0, 8'h5A);
    fork
      do_txn(0, 1'b0, 25'h000123, 8'h00, la);
      do_txn(1, 1'b0, 25'h000200, 8'h00, lb);
    join
    drain(200);
    check_val("simul_first_port", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    check_val("simul_p1_after_rvalid", t_gnt1 - t_rv0, 1);

    // Both ports held for six transactions: strict alternation.
    gnt_log.delete();
    push_exp(0, 1'b0, 8'h77); push_exp(1, 1'b0, 8'hFF);
    push_exp(0, 1'b0, 8'h5A); push_exp(1, 1'b0, 8'h77);
    push_exp(0, 1'b0, 8'hFF); push_exp(1, 1'b0, 8'h5A);
    fork
      begin
        int l0;
        do_txn(0, 1'b0, 25'h000123, 8'h00, l0);
        do_txn(0, 1'b0, 25'h000200, 8'h00, l0);
        do_txn(0, 1'b0, 25'h0003FF, 8'h00, l0);
      end
      begin
        int l1;
        do_txn(1, 1'b0, 25'h0003FF, 8'h00, l1);
        do_txn(1, 1'b0, 25'h000123, 8'h00, l1);
        do_txn(1, 1'b0, 25'h000200, 8'h00, l1);
      end
    join
    drain(300);
    check_val("alt_count", gnt_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("alt_gnt%0d", i), (i < gnt_log.size()) ? gnt_log[i] : -1, alt_exp[i]);
    end

    // Refresh collides with a p1 write: strobe waits for ack.
    wr_strobe_cycles = 0;
    push_exp(1, 1'b1, 8'h00);
    force_refresh = 1'b1;
    fork
      do_txn(1, 1'b1, 25'h0000AB, 8'h3C, la);
      begin @(negedge clk); force_refresh = 1'b0; end
    join
    drain(200);
    checks++;
    if (wr_strobe_cycles < REF_LEN) begin
      errors++;
      $display("FAIL refresh_wait: strobe cycles=%0d, required >= %0d", wr_strobe_cycles, REF_LEN);
    end
    push_exp(1, 1'b0, 8'h3C);
    do_txn(1, 1'b0, 25'h0000AB, 8'h00, lat);
    drain(200);
    check_val("err_after_refresh", int'(err), 0);

    // Controller never acks: abort after exactly 64 cycles.
    no_ack = 1'b1;
    do_txn(0, 1'b0, 25'h000010, 8'h00, lat);
    n = 0;
    while (!err && n < 150) begin @(negedge clk); n++; end
    @(negedge clk);
    check_val("timeout_err", int'(err), 1);
    check_val("timeout_cycles", t_err - t_gnt0, 64);
    check_val("timeout_idle", int'(sd_rd_enable | sd_wr_enable), 0);
    no_ack = 1'b0;
    push_exp(0, 1'b0, 8'h3C);
    do_txn(0, 1'b0, 25'h0000AB, 8'h00, lat);
    check_val("post_timeout_latency", lat, 1);
    drain(200);
    check_val("err_sticky", int'(err), 1);

    // Reset while a p0 read sits in WAIT_RD.
    do_txn(0, 1'b0, 25'h000200, 8'h00, lat);
    @(negedge clk);
    check_val("strobe_dropped", int'(sd_rd_enable), 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_read");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // After reset, port 0 wins contention again.
    gnt_log.delete();
    push_exp(0, 1'b0, 8'h3C);
    push_exp(1, 1'b0, 8'h5A);
    fork
      do_txn(0, 1'b0, 25'h0000AB, 8'h00, la);
      do_txn(1, 1'b0, 25'h000200, 8'h00, lb);
    join
    drain(200);
    check_val("post_reset_first", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
